// File: rtl/gate_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gate_pkg: opcodes and FSM encoding shared by gate-level model drivers |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package gate_pkg;

  localparam logic [1:0] OP_HOLD    = 2'b00;
  localparam logic [1:0] OP_RESET   = 2'b01;
  localparam logic [1:0] OP_SET     = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync2: parameterized-width two-flop synchronizer, sync active-high rst|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/rs_latch_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rs_latch_driver: pulses an RS latch per command and checks its state |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rs_latch_driver
  import gate_pkg::*;
#(
  parameter int PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_expect,
  output logic       set,
  output logic       reset,
  input  logic       q,
  input  logic       q_bar,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_q,
  output logic       rsp_ok,
  output logic       rsp_err
);

  localparam int CNT_W = $clog2(max_int(PULSE_CYCLES, SETTLE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] C_PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic             r_expect;
  logic             r_set;
  logic             r_reset;
  logic             r_rsp_valid;
  logic             r_rsp_q;
  logic             r_rsp_ok;
  logic             r_rsp_err;
  logic             w_accept;
  logic [1:0]       w_op;
  logic             w_set_d;
  logic             w_reset_d;
  logic [1:0]       w_sync;
  logic             w_qs;
  logic             w_qbs;

  sync2 #(.WIDTH(2)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d ({q, q_bar}),
    .o_q (w_sync)
  );

  assign w_qs  = w_sync[1];
  assign w_qbs = w_sync[0];

  assign cmd_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept  = cmd_ready && cmd_valid;
  // On the accept cycle the opcode comes straight from the command bus.
  assign w_op      = (r_state == ST_IDLE) ? cmd_op : r_op;

  always_comb begin
    w_next    = r_state;
    w_set_d   = 1'b0;
    w_reset_d = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = (cmd_op == OP_ILLEGAL) ? ST_RESP : ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == '0) w_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_cnt == '0) w_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        w_next = ST_RESP;
      end
      ST_RESP: begin
        if (r_rsp_valid && rsp_ready) w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
    // Pulse outputs are registered from the next state, so at most one is high.
    if (w_next == ST_DRIVE) begin
      w_set_d   = (w_op == OP_SET);
      w_reset_d = (w_op == OP_RESET);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_op        <= OP_HOLD;
      r_expect    <= 1'b0;
      r_set       <= 1'b0;
      r_reset     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_q     <= 1'b0;
      r_rsp_ok    <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_set   <= w_set_d;
      r_reset <= w_reset_d;

      if (w_accept) begin
        r_op     <= cmd_op;
        r_expect <= cmd_expect;
        r_cnt    <= C_PULSE_LOAD;
      end else if ((r_state == ST_DRIVE) && (r_cnt == '0)) begin
        r_cnt <= C_SETTLE_LOAD;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_accept && (cmd_op == OP_ILLEGAL)) begin
        r_rsp_q   <= 1'b0;
        r_rsp_ok  <= 1'b0;
        r_rsp_err <= 1'b1;
      end else if (r_state == ST_SAMPLE) begin
        r_rsp_q     <= w_qs;
        r_rsp_err   <= (w_qs == w_qbs);
        r_rsp_ok    <= (w_qs != w_qbs) && (w_qs == r_expect);
        r_rsp_valid <= 1'b1;
      end

      // An illegal command enters RESP with valid still low; raise it one edge later.
      if (r_state == ST_RESP) begin
        if (!r_rsp_valid) begin
          r_rsp_valid <= 1'b1;
        end else if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
        end
      end
    end
  end

  assign set       = r_set;
  assign reset     = r_reset;
  assign rsp_valid = r_rsp_valid;
  assign rsp_q     = r_rsp_q;
  assign rsp_ok    = r_rsp_ok;
  assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_rs_latch_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rs_latch_driver: drives rs_latch_driver into a NOR-pair RS latch   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rs_latch_driver;
  import gate_pkg::*;

  localparam int P = 4;
  localparam int S = 2;

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic       cmd_valid  = 1'b0;
  logic [1:0] cmd_op     = 2'b00;
  logic       cmd_expect = 1'b0;
  logic       rsp_ready  = 1'b0;
  logic       cmd_ready;
  logic       set_o;
  logic       reset_o;
  logic       rsp_valid;
  logic       rsp_q;
  logic       rsp_ok;
  logic       rsp_err;

  // Cross-coupled NOR latch with 2 ns gate delay against a 20 ns clock.
  logic lq  = 1'b0;
  logic lqb = 1'b1;
  always @(reset_o or lqb) lq  <= #2 ~(reset_o | lqb);
  always @(set_o or lq)    lqb <= #2 ~(set_o | lq);

  always #10 clk = ~clk;

  rs_latch_driver #(.PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_expect (cmd_expect),
    .set        (set_o),
    .reset      (reset_o),
    .q          (lq),
    .q_bar      (lqb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_q      (rsp_q),
    .rsp_ok     (rsp_ok),
    .rsp_err    (rsp_err)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one command in flight, m_k counts edges since its accept edge.
  logic       m_on    = 1'b0;
  logic       m_busy  = 1'b0;
  int         m_k     = 0;
  logic [1:0] m_op    = 2'b00;
  logic       m_exp   = 1'b0;
  logic       m_latch = 1'b0;
  logic       e_ready, e_set, e_reset, e_valid, e_q, e_ok, e_err;

  assign e_ready = !m_busy && !rst;
  assign e_set   = m_busy && (m_op == OP_SET)   && (m_k < P);
  assign e_reset = m_busy && (m_op == OP_RESET) && (m_k < P);
  assign e_valid = m_busy && ((m_op == OP_ILLEGAL) ? (m_k >= 1) : (m_k >= P + S + 1));
  assign e_err   = (m_op == OP_ILLEGAL);
  assign e_q     = e_err ? 1'b0 : m_latch;
  assign e_ok    = !e_err && (m_latch == m_exp);

  always @(posedge clk) begin
    m_on <= 1'b1;
    if (rst) begin
      m_busy <= 1'b0;
      m_k    <= 0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_busy <= 1'b1;
        m_k    <= 0;
        m_op   <= cmd_op;
        m_exp  <= cmd_expect;
        if (cmd_op == OP_SET)        m_latch <= 1'b1;
        else if (cmd_op == OP_RESET) m_latch <= 1'b0;
      end
    end else if (e_valid && rsp_ready) begin
      m_busy <= 1'b0;
    end else if (m_k < 1000) begin
      m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("cmd_ready", {7'd0, cmd_ready}, {7'd0, e_ready});
      chk("set", {7'd0, set_o}, {7'd0, e_set});
      chk("reset", {7'd0, reset_o}, {7'd0, e_reset});
      chk("set_and_reset", {7'd0, set_o & reset_o}, 8'd0);
      chk("rsp_valid", {7'd0, rsp_valid}, {7'd0, e_valid});
      if (e_valid) begin
        chk("rsp_q", {7'd0, rsp_q}, {7'd0, e_q});
        chk("rsp_ok", {7'd0, rsp_ok}, {7'd0, e_ok});
        chk("rsp_err", {7'd0, rsp_err}, {7'd0, e_err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic expv, input int lat,
                        input int set_w, input int rst_w, input logic xq,
                        input logic xok, input logic xerr, input int hold);
    int n  = 0;
    int sw = 0;
    int rw = 0;
    tick();
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_expect = expv;
    tick();
    cmd_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid || n >= 40) break;
      sw += int'(set_o);
      rw += int'(reset_o);
      n++;
    end
    chk("latency", 8'(n), 8'(lat));
    chk("set_width", 8'(sw), 8'(set_w));
    chk("reset_width", 8'(rw), 8'(rst_w));
    chk("lit_rsp_q", {7'd0, rsp_q}, {7'd0, xq});
    chk("lit_rsp_ok", {7'd0, rsp_ok}, {7'd0, xok});
    chk("lit_rsp_err", {7'd0, rsp_err}, {7'd0, xerr});
    repeat (hold) tick();
    tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk("rst_set", {7'd0, set_o}, 8'd0);
    chk("rst_reset", {7'd0, reset_o}, 8'd0);
    chk("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    chk("rst_cmd_ready", {7'd0, cmd_ready}, 8'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {7'd0, cmd_ready}, 8'd1);

    do_cmd(OP_RESET,   1'b0, 7, 0, 4, 1'b0, 1'b1, 1'b0, 0);
    do_cmd(OP_SET,     1'b1, 7, 4, 0, 1'b1, 1'b1, 1'b0, 0);
    do_cmd(OP_HOLD,    1'b1, 7, 0, 0, 1'b1, 1'b1, 1'b0, 0);
    do_cmd(OP_SET,     1'b0, 7, 4, 0, 1'b1, 1'b0, 1'b0, 0);
    do_cmd(OP_ILLEGAL, 1'b0, 1, 0, 0, 1'b0, 1'b0, 1'b1, 5);
    do_cmd(OP_RESET,   1'b1, 7, 0, 4, 1'b0, 1'b0, 1'b0, 2);

    // Reset lands in the second DRIVE cycle of a SET.
    tick();
    cmd_valid  = 1'b1;
    cmd_op     = OP_SET;
    cmd_expect = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_set_before", {7'd0, set_o}, 8'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_set_dropped", {7'd0, set_o}, 8'd0);
    chk("mid_no_rsp", {7'd0, rsp_valid}, 8'd0);
    repeat (12) tick();
    do_cmd(OP_RESET, 1'b0, 7, 0, 4, 1'b0, 1'b1, 1'b0, 0);

    repeat (3) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/rs_latch_driver.md
# rs_latch_driver

Synchronous command-driven stimulus engine for the gate-level RS latch models. It accepts one latch operation per command and drives the latch's `set`/`reset` inputs with a clean pulse of fixed width. Both outputs are never asserted together. After a settle window it samples the latch's `q`/`q_bar` through a synchronizer and returns a checked response. It is the driving end of the set/reset interface, used by gate-modelling benches and by any clocked logic that controls an RS latch.

## Interface
- `PULSE_CYCLES`, default 4: width of the set/reset pulse in clock cycles; must be ≥1.
- `SETTLE_CYCLES`, default 2: idle cycles after the pulse before sampling; must be ≥2 to cover synchronizer latency.
- `clk` in 1: the only clock; all state is updated on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: a command is present.
- `cmd_ready` out 1: the block can accept a command.
- `cmd_op` in 2: operation code. 00 = HOLD, 01 = RESET, 10 = SET, 11 = ILLEGAL.
- `cmd_expect` in 1: the `q` value expected after the operation.
- `set` out 1: drives the latch `set` input.
- `reset` out 1: drives the latch `reset` input.
- `q` in 1: latch output. It is asynchronous to `clk`.
- `q_bar` in 1: latch complementary output. It is asynchronous to `clk`.
- `rsp_valid` out 1: a response is present.
- `rsp_ready` in 1: the consumer accepts the response.
- `rsp_q` out 1: the synchronized `q` value at the sample point.
- `rsp_ok` out 1: the check passed.
- `rsp_err` out 1: the command was illegal, or the latch was found in an invalid state.

## Operation
- FSM states: IDLE → DRIVE → SETTLE → SAMPLE → RESP → IDLE.
- **IDLE**
  - `cmd_ready` = (state==IDLE) && !rst.
  - On cmd_valid && cmd_ready, the command is latched and the next state is DRIVE.
  - Exception: op 11 goes straight to RESP with `rsp_err`=1, `rsp_ok`=0, `rsp_q`=0, and no pulse.
- **DRIVE**
  - Lasts PULSE_CYCLES cycles.
  - SET drives `set`=1, `reset`=0. RESET drives `reset`=1, `set`=0. HOLD drives both 0.
  - `set` and `reset` are registered. `set && reset` is unreachable; the verifier asserts this every cycle.
- **SETTLE**
  - Lasts SETTLE_CYCLES cycles with `set` = `reset` = 0.
- **SAMPLE**
  - Lasts one cycle and uses the synchronized values q_s and qb_s.
  - `rsp_q` = q_s.
  - `rsp_err` = (q_s == qb_s).
  - `rsp_ok` = !rsp_err && (q_s == cmd_expect).
- **RESP**
  - `rsp_valid`=1, and all `rsp_*` outputs stay stable until rsp_valid && rsp_ready; then the next state is IDLE.
  - No new command is accepted while in RESP.
- The phase counter is $clog2(max(PULSE_CYCLES, SETTLE_CYCLES)+1) bits wide, counts down, and reloads on each phase entry.
- HOLD follows the same timing as SET/RESET, so latency does not depend on the op.

## Timing
- **Reset values** (on any edge with rst=1): state IDLE; `set`, `reset`, `rsp_valid`, `rsp_q`, `rsp_ok`, `rsp_err` all 0; synchronizer flops 0; `cmd_ready`=0 while rst is high.
- **Reset mid-operation** aborts the command. `set`/`reset` drop at that edge, and no response is produced.
- **Pulse timing:** with the accept edge called E0, the pulse is high from E0 to E(P).
- **Response timing:** SAMPLE registers at E(P+S+1), and `rsp_valid` rises at E(P+S+1), which is 7 cycles at the defaults.
- **ILLEGAL:** `rsp_valid` rises at E1.
- **Synchronizer:** 2 flops. The latch must resolve within one clock period of pulse start, so the bench clock period must be at least 4× the latch gate delay.
- **Throughput:** back-to-back commands are allowed. With rsp_ready held at 1, the minimum command spacing is P+S+3 cycles, because `cmd_ready` re-asserts at the edge following the response handshake.
- **Simultaneous events:** a cmd_valid that arrives in the same cycle as the response handshake is not accepted until the next cycle.

## Structure
- **Shared package `gate_pkg`:**
  - opcode localparams OP_HOLD, OP_RESET, OP_SET, OP_ILLEGAL;
  - FSM state encoding;
  - these are shared with future latch/flip-flop drivers.
- **Sub-module `sync2`:** a parameterized-width 2-flop synchronizer with synchronous active-high reset, instantiated once with width 2 for {q, q_bar}.
- Everything else lives in `rs_latch_driver`.

## Test plan
All scenarios use P=4, S=2, with the DUT connected to the gate-level RS latch model.
- **Reset:** rst=1 for 3 cycles → `set`=`reset`=0, `rsp_valid`=0, `cmd_ready`=0. After release, `cmd_ready`=1 on the next cycle.
- **RESET:** RESET with expect 0 → `reset` high for exactly 4 cycles and `set` stays 0; `rsp_valid` 7 cycles after accept with `rsp_q`=0, `rsp_ok`=1, `rsp_err`=0.
- **SET then HOLD:** SET with expect 1, then HOLD with expect 1 → `set` pulses for 4 cycles and HOLD produces no pulse; both responses give `rsp_ok`=1, `rsp_q`=1.
- **Mismatch:** SET with expect 0 → `rsp_q`=1, `rsp_ok`=0, `rsp_err`=0.
- **ILLEGAL with backpressure:** op 11 with rsp_ready held low for 5 cycles → no pulse; `rsp_valid` at E1 with `rsp_err`=1, all `rsp_*` outputs stable, `cmd_ready`=0 until the handshake.
- **Reset mid-DRIVE:** rst asserted during the 2nd DRIVE cycle of a SET → `set`=0 at that edge and no `rsp_valid`; a following RESET command completes normally.
